// File: rtl/instr_sequencer.sv
// Streams a loadable program onto the processor's iin port, holding each word
// for a fixed number of cycles and stopping at the halt sentinel or the last address.
module instr_sequencer #(
    parameter int              WIDTH       = 16,
    parameter int              AW          = 4,
    parameter int              SLOT_CYCLES = 4,
    parameter logic [WIDTH-1:0] HALT_WORD  = 16'hFFFF,
    parameter logic [WIDTH-1:0] IDLE_WORD  = 16'h0000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    output logic [WIDTH-1:0] iin,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             halted
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [AW-1:0] PC_LAST   = {AW{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t           state;
    logic [CW-1:0]    slot;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    pc_nx;

    assign pc_nx = pc + AW'(1);

    // Writes only land while stopped, never alongside an accepted start or during reset.
    always_ff @(posedge clock) begin
        if (resetn && load_en && !start && state != RUN)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            iin    <= IDLE_WORD;
            pc     <= '0;
            busy   <= 1'b0;
            halted <= 1'b0;
            slot   <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc   <= '0;
                        slot <= '0;
                        if (mem[0] == HALT_WORD) begin
                            state  <= HALTED;
                            iin    <= IDLE_WORD;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state  <= RUN;
                            iin    <= mem[0];
                            busy   <= 1'b1;
                            halted <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (slot == SLOT_LAST) begin
                        slot <= '0;
                        // pc never wraps; it keeps the last executed address when halting.
                        if (pc == PC_LAST || mem[pc_nx] == HALT_WORD) begin
                            state  <= HALTED;
                            iin    <= IDLE_WORD;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            pc  <= pc_nx;
                            iin <= mem[pc_nx];
                        end
                    end else begin
                        slot <= slot + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    iin    <= IDLE_WORD;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, basic program, full memory,
// immediate halt, ignored requests and reset mid-run.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        load_en = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [15:0] iin;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;

    int total = 0;
    int bad = 0;

    instr_sequencer #(
        .WIDTH(16), .AW(4), .SLOT_CYCLES(4),
        .HALT_WORD(16'hFFFF), .IDLE_WORD(16'h0000)
    ) dut (
        .clock(clock), .resetn(resetn), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .iin(iin), .pc(pc),
        .busy(busy), .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Observed vector is {busy, halted, pc, iin}.
    task automatic test_reset;
        logic [21:0] exp;
        resetn = 1'b0;
        tick(); tick();
        exp = {1'b0, 1'b0, 4'd0, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL reset_initial got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        resetn = 1'b1;
        load(4'd0, 16'hA000);
        load(4'd1, 16'hFFFF);
        resetn = 1'b0;
        load_en = 1'b1; load_addr = 4'd0; load_data = 16'h5555; start = 1'($urandom_range(0, 1));
        tick();
        load_en = 1'($urandom_range(0, 1)); load_data = 16'h5555; start = 1'($urandom_range(0, 1));
        tick();
        load_en = 1'b0; start = 1'b0;
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL reset_noisy got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        resetn = 1'b1;
        tick();
        pulse_start();
        exp = {1'b1, 1'b0, 4'd0, 16'hA000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL reset_mem_kept got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        repeat (4) tick();
        exp = {1'b0, 1'b1, 4'd0, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL reset_run_end got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
    endtask

    task automatic test_basic;
        logic [15:0] prog [4] = '{16'h202A, 16'hE400, 16'h8400, 16'hFFFF};
        logic [21:0] exp;
        for (int i = 0; i < 4; i++) load(4'(i), prog[i]);
        pulse_start();
        for (int c = 0; c < 12; c++) begin
            exp = {1'b1, 1'b0, 4'(c / 4), prog[c / 4]};
            total++;
            if ({busy, halted, pc, iin} !== exp) begin
                bad++; $display("FAIL basic_c%0d got=%h exp=%h", c, {busy, halted, pc, iin}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b1, 4'd2, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL basic_halt got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
    endtask

    task automatic test_full_memory;
        logic [21:0] exp;
        for (int i = 0; i < 16; i++) load(4'(i), 16'(i * 16'h0101 + 1));
        pulse_start();
        for (int c = 0; c < 64; c++) begin
            exp = {1'b1, 1'b0, 4'(c / 4), 16'((c / 4) * 16'h0101 + 1)};
            total++;
            if ({busy, halted, pc, iin} !== exp) begin
                bad++; $display("FAIL full_c%0d got=%h exp=%h", c, {busy, halted, pc, iin}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b1, 4'd15, 16'h0000};
        repeat (2) begin
            total++;
            if ({busy, halted, pc, iin} !== exp) begin
                bad++; $display("FAIL full_end got=%h exp=%h", {busy, halted, pc, iin}, exp);
            end
            tick();
        end
    endtask

    task automatic test_immediate_halt;
        logic [21:0] exp;
        load(4'd0, 16'hFFFF);
        pulse_start();
        exp = {1'b0, 1'b1, 4'd0, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL imm_halt got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        load(4'd0, 16'h8400);
        load(4'd1, 16'hFFFF);
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            exp = {1'b1, 1'b0, 4'd0, 16'h8400};
            total++;
            if ({busy, halted, pc, iin} !== exp) begin
                bad++; $display("FAIL rerun_c%0d got=%h exp=%h", c, {busy, halted, pc, iin}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b1, 4'd0, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL rerun_halt got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
    endtask

    task automatic test_ignored;
        logic [15:0] prog [2] = '{16'hA000, 16'hA001};
        logic [21:0] exp;
        load(4'd0, prog[0]);
        load(4'd1, prog[1]);
        load(4'd2, 16'hFFFF);
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            exp = {1'b1, 1'b0, 4'(c / 4), prog[c / 4]};
            total++;
            if ({busy, halted, pc, iin} !== exp) begin
                bad++; $display("FAIL ignored_c%0d got=%h exp=%h", c, {busy, halted, pc, iin}, exp);
            end
            if (c == 2) begin
                load_en = 1'b1; load_addr = 4'd1; load_data = 16'h1234; start = 1'b1;
            end
            tick();
            load_en = 1'b0; start = 1'b0;
        end
        exp = {1'b0, 1'b1, 4'd1, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL ignored_halt got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        resetn = 1'b0; tick(); resetn = 1'b1;
        load_en = 1'b1; load_addr = 4'd0; load_data = 16'h1234; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        exp = {1'b1, 1'b0, 4'd0, 16'hA000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL load_with_start got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        repeat (4) tick();
        exp = {1'b1, 1'b0, 4'd1, 16'hA001};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL run_write_dropped got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_run;
        logic [21:0] exp;
        pulse_start();
        repeat (5) tick();
        exp = {1'b1, 1'b0, 4'd1, 16'hA001};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL midrun_pre got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        exp = {1'b0, 1'b0, 4'd0, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL midrun_reset got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            exp = {1'b1, 1'b0, 4'(c / 4), (c < 4) ? 16'hA000 : 16'hA001};
            total++;
            if ({busy, halted, pc, iin} !== exp) begin
                bad++; $display("FAIL midrun_rerun_c%0d got=%h exp=%h", c, {busy, halted, pc, iin}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b1, 4'd1, 16'h0000};
        total++;
        if ({busy, halted, pc, iin} !== exp) begin
            bad++; $display("FAIL midrun_halt got=%h exp=%h", {busy, halted, pc, iin}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_memory();
        test_immediate_halt();
        test_ignored();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program-streaming source for the processor's `iin` instruction port. It holds a small loadable program memory and presents one instruction word per fixed-length execution slot. This replaces hand-timed testbench stimulus. It sits between a loader (bench or host) and `processor.iin`, and runs on the processor's clock.

## Interface
Parameters:
- `WIDTH`, 16: instruction word width; must equal the `iin` width.
- `AW`, 4: program address width; DEPTH = 2**AW words.
- `SLOT_CYCLES`, 4: clock cycles each word is held on `iin`; legal range ≥ 2.
- `HALT_WORD`, 16'hFFFF: sentinel word that ends a run; it is never driven on `iin`.
- `IDLE_WORD`, 16'h0000: value driven on `iin` when not running.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: reset is synchronous and active-low.
- `load_en`  in  1: write strobe for program memory.
- `load_addr`  in  AW: write address.
- `load_data`  in  WIDTH: write data.
- `start`  in  1: single-cycle request to run the program from address 0.
- `iin`  out  WIDTH: instruction word to the processor; registered.
- `pc`  out  AW: address of the word currently on `iin`.
- `busy`  out  1: high while in RUN.
- `halted`  out  1: high in HALTED, i.e. after a run ends, until the next start or reset.

## Operation
- States are IDLE, RUN and HALTED. Reset puts the block in IDLE with `iin`=IDLE_WORD, `pc`=0, `busy`=0, `halted`=0 and slot counter 0. Program memory is not cleared by reset.
- Loading happens only in IDLE or HALTED. A write `mem[load_addr] <= load_data` occurs when `load_en`=1.
  - `load_en` during RUN is ignored.
  - `load_en` in the same cycle as an accepted `start` is ignored.
- An accepted `start` (in IDLE or HALTED) sets `pc`=0, clears the slot counter and `halted`, and enters RUN.
  - If mem[0]==HALT_WORD, the block goes directly to HALTED with `iin`=IDLE_WORD.
- `start` during RUN is ignored; there is no restart.
- In RUN, `iin`=mem[`pc`] for exactly SLOT_CYCLES cycles. In the last slot cycle:
  - If `pc`==DEPTH-1, the block enters HALTED. `pc` does not wrap.
  - Otherwise, if mem[`pc`+1]==HALT_WORD, the block enters HALTED and `pc` stays at the last executed address.
  - Otherwise `pc` increments and the next word is presented.
- On entering HALTED: `iin`=IDLE_WORD, `busy`=0, `halted`=1.
- Deasserting `resetn` mid-run aborts the run on that edge and returns the block to the reset state, with no partial slot.
- Addresses are unsigned AW bits. The slot counter is ceil(log2(SLOT_CYCLES)) bits and counts 0..SLOT_CYCLES-1.

## Timing
- `start` sampled at edge t gives `busy`=1 and `iin`=mem[0] from edge t+1. The first word has no extra fetch latency; reads are combinational from memory into the `iin` register.
- Word k appears at edge t+1+k·SLOT_CYCLES and is stable for SLOT_CYCLES cycles. It has no glitch, because `iin` changes only at slot boundaries.
- A program of N non-halt words followed by HALT_WORD gives `busy`=1 for N·SLOT_CYCLES cycles. `halted` rises at edge t+1+N·SLOT_CYCLES in the same cycle `iin` returns to IDLE_WORD.
- A write at edge e is visible to a `start` accepted at edge e+1 or later.
- `halted` and `busy` are never high together. `pc` is valid whenever `busy`=1 and holds its value in HALTED.

## Test plan
- Reset behaviour: hold `resetn`=0 for 2 cycles with random `load_en`/`start`. Then `iin`=16'h0000, `busy`=0, `halted`=0, `pc`=0, and memory is unchanged.
- Basic program, ldi/rep/out: load mem[0]=ldi r0,#42, mem[1]=16'hE400, mem[2]=16'h8400, mem[3]=16'hFFFF, then pulse `start`.
  - Each word is held 4 cycles and `busy`=1 for 12 cycles.
  - `halted` rises at cycle 13 and `iin` returns to 16'h0000.
  - With `processor` attached, `bus`=42 during the `out` slot.
- Full memory: fill all 16 words with non-halt values and start. The block runs 64 cycles, ends with `pc`=15, shows no wrap to 0, and sets `halted`=1.
- Immediate halt and re-run: set mem[0]=16'hFFFF and start; `busy` never rises and `halted`=1 the next cycle. Then load mem[0]=16'h8400 and start again; the run proceeds normally.
- Ignored requests: during RUN, assert `load_en` (addr 1, data 16'h1234) and `start`. The memory word and the slot sequence are unchanged. Also assert `load_en` together with `start` in IDLE; the write is dropped.
- Reset mid-run: deassert `resetn` in the 2nd cycle of slot 1. The next edge gives the IDLE reset state; a following `start` re-runs from mem[0] with the original contents.
